// File: rtl/sccomp.sv
// sccomp: single-cycle RV32I-subset core with instruction ROM, data RAM and
// a combinational debug read port into the register file.
// Build option: define SCCOMP_JALR_EN to execute jalr; otherwise it is a NOP.

// Instruction ROM, word-indexed by PC with wrap; contents are preloaded
// hierarchically through U_IM.ROM.
module sccomp_im #(
  parameter int unsigned IM_WORDS = 128
) (
  input  logic [31:0] pc,
  output logic [31:0] instr
);
  localparam int unsigned AW = (IM_WORDS > 1) ? $clog2(IM_WORDS) : 1;

  logic [31:0] ROM [0:IM_WORDS-1];

  // Combinational fetch; byte offset bits are dropped by the shift
  always_comb begin
    instr = ROM[AW'((pc >> 2) % 32'(IM_WORDS))];
  end
endmodule

module sccomp #(
  parameter int unsigned IM_WORDS = 128,
  parameter int unsigned DM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
);
  localparam int unsigned DW = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
`ifdef SCCOMP_JALR_EN
  localparam logic [6:0] OP_JALR   = 7'b1100111;
`endif

  logic [31:0] PC;
  logic [31:0] instr;

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [32];
  logic [31:0] dm_q [DM_WORDS];

  logic        rf_we_d;
  logic [31:0] rf_wd_d;
  logic        dm_we_d;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] pc_plus4;
  logic [31:0] mem_addr;
  logic [DW-1:0] dm_idx;
  logic [31:0] dm_rdata;

  assign PC = pc_q;

  sccomp_im #(.IM_WORDS(IM_WORDS)) U_IM (
    .pc    (PC),
    .instr (instr)
  );

  // Field extraction and immediate formats
  always_comb begin
    opcode = instr[6:0];
    rd     = instr[11:7];
    funct3 = instr[14:12];
    rs1    = instr[19:15];
    rs2    = instr[24:20];
    funct7 = instr[31:25];
    imm_i  = {{20{instr[31]}}, instr[31:20]};
    imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u  = {instr[31:12], 12'b0};
    imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  end

  // Register reads (old value during a same-cycle write) and data RAM read
  always_comb begin
    rs1_val  = rf_q[rs1];
    rs2_val  = rf_q[rs2];
    reg_data = rf_q[reg_sel];
    pc_plus4 = pc_q + 32'd4;
    mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    dm_idx   = DW'((mem_addr >> 2) % 32'(DM_WORDS));
    dm_rdata = dm_q[dm_idx];
  end

  // Execute: write-back value, store enable and next PC; unknown encodings fall to NOP
  always_comb begin
    pc_d    = pc_plus4;
    rf_we_d = 1'b0;
    rf_wd_d = 32'd0;
    dm_we_d = 1'b0;
    case (opcode)
      OP_REG: begin
        rf_we_d = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: rf_wd_d = rs1_val + rs2_val;
          10'b0100000_000: rf_wd_d = rs1_val - rs2_val;
          10'b0000000_001: rf_wd_d = rs1_val << rs2_val[4:0];
          10'b0000000_010: rf_wd_d = {31'd0, $signed(rs1_val) < $signed(rs2_val)};
          10'b0000000_011: rf_wd_d = {31'd0, rs1_val < rs2_val};
          10'b0000000_100: rf_wd_d = rs1_val ^ rs2_val;
          10'b0000000_101: rf_wd_d = rs1_val >> rs2_val[4:0];
          10'b0100000_101: rf_wd_d = $signed(rs1_val) >>> rs2_val[4:0];
          10'b0000000_110: rf_wd_d = rs1_val | rs2_val;
          10'b0000000_111: rf_wd_d = rs1_val & rs2_val;
          default:         rf_we_d = 1'b0;
        endcase
      end
      OP_IMM: begin
        rf_we_d = 1'b1;
        case (funct3)
          3'b000: rf_wd_d = rs1_val + imm_i;
          3'b010: rf_wd_d = {31'd0, $signed(rs1_val) < $signed(imm_i)};
          3'b011: rf_wd_d = {31'd0, rs1_val < imm_i};
          3'b100: rf_wd_d = rs1_val ^ imm_i;
          3'b110: rf_wd_d = rs1_val | imm_i;
          3'b111: rf_wd_d = rs1_val & imm_i;
          3'b001: begin
            if (funct7 == 7'b0000000) rf_wd_d = rs1_val << rs2;
            else                      rf_we_d = 1'b0;
          end
          default: begin
            if (funct7 == 7'b0000000)      rf_wd_d = rs1_val >> rs2;
            else if (funct7 == 7'b0100000) rf_wd_d = $signed(rs1_val) >>> rs2;
            else                           rf_we_d = 1'b0;
          end
        endcase
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          rf_we_d = 1'b1;
          rf_wd_d = dm_rdata;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) dm_we_d = 1'b1;
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000: if (rs1_val == rs2_val) pc_d = pc_q + imm_b;
          3'b001: if (rs1_val != rs2_val) pc_d = pc_q + imm_b;
          3'b100: if ($signed(rs1_val) < $signed(rs2_val)) pc_d = pc_q + imm_b;
          3'b101: if ($signed(rs1_val) >= $signed(rs2_val)) pc_d = pc_q + imm_b;
          default: ;
        endcase
      end
      OP_LUI: begin
        rf_we_d = 1'b1;
        rf_wd_d = imm_u;
      end
      OP_JAL: begin
        rf_we_d = 1'b1;
        rf_wd_d = pc_plus4;
        pc_d    = pc_q + imm_j;
      end
`ifdef SCCOMP_JALR_EN
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          rf_we_d = 1'b1;
          rf_wd_d = pc_plus4;
          pc_d    = (rs1_val + imm_i) & ~32'd1;
        end
      end
`endif
      default: ;
    endcase
  end

  // PC and register file; reset clears both and drops the current write-back
  always_ff @(posedge clk) begin
    if (rstn) begin
      pc_q <= 32'd0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      pc_q <= pc_d;
      if (rf_we_d && (rd != 5'd0)) rf_q[rd] <= rf_wd_d;
    end
  end

  // Data RAM keeps its contents through reset; stores are blocked while in reset
  always_ff @(posedge clk) begin
    if (!rstn && dm_we_d) dm_q[dm_idx] <= rs2_val;
  end
endmodule

// File: tb/tb_sccomp.sv
// Directed self-checking bench for sccomp; hand-assembled programs are
// written straight into U_IM.ROM and results observed via reg_data and PC.
module tb_sccomp;
  logic        clk;
  logic        rstn;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  sccomp dut (
    .clk      (clk),
    .rstn     (rstn),
    .reg_sel  (reg_sel),
    .reg_data (reg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] sel, input logic [31:0] exp);
    reg_sel = sel;
    #1;
    check(tag, reg_data, exp);
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] exp);
    check(tag, dut.PC, exp);
  endtask

  task automatic clear_rom;
    for (int i = 0; i < 128; i++) dut.U_IM.ROM[i] = NOP;
  endtask

  // One rising edge with reset high, then release on the falling edge
  task automatic do_reset;
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rstn    = 1'b1;
    reg_sel = 5'd0;

    // Program 1: addi/addi/add
    clear_rom();
    dut.U_IM.ROM[0] = 32'h00500093;  // addi x1,x0,5
    dut.U_IM.ROM[1] = 32'hFFD00113;  // addi x2,x0,-3
    dut.U_IM.ROM[2] = 32'h002083B3;  // add  x7,x1,x2
    step(2);
    rstn = 1'b0;
    chk_pc("reset_pc", 32'h0);
    chk_reg("reset_x7", 5'd7, 32'h0);
    check("reset_instr", dut.instr, 32'h00500093);
    step(3);
    chk_reg("p1_x1", 5'd1, 32'h00000005);
    chk_reg("p1_x2", 5'd2, 32'hFFFFFFFD);
    chk_reg("p1_x7", 5'd7, 32'h00000002);
    chk_pc("p1_pc", 32'h0000000C);

    // Mid-run reset before add executes, then identical re-run
    do_reset();
    step(2);
    chk_pc("rr_pc_pre", 32'h8);
    do_reset();
    chk_pc("rr_pc_zero", 32'h0);
    chk_reg("rr_x7_zero", 5'd7, 32'h0);
    chk_reg("rr_x1_zero", 5'd1, 32'h0);
    step(3);
    chk_reg("rr_x7", 5'd7, 32'h00000002);
    chk_pc("rr_pc", 32'h0000000C);

    // Program 2: jal skips one instruction
    clear_rom();
    dut.U_IM.ROM[0] = 32'h008003EF;  // jal  x7,+8
    dut.U_IM.ROM[1] = 32'h00100293;  // addi x5,x0,1
    dut.U_IM.ROM[2] = 32'h00200313;  // addi x6,x0,2
    do_reset();
    chk_pc("p2_pc0", 32'h0);
    step(1);
    chk_pc("p2_pc1", 32'h8);
    step(1);
    chk_pc("p2_pc2", 32'hC);
    chk_reg("p2_x7", 5'd7, 32'h00000004);
    chk_reg("p2_x5", 5'd5, 32'h0);
    chk_reg("p2_x6", 5'd6, 32'h00000002);

    // Program 3: store/load round trip and write to x0
    clear_rom();
    dut.U_IM.ROM[0] = 32'h05500093;  // addi x1,x0,0x55
    dut.U_IM.ROM[1] = 32'h00102423;  // sw   x1,8(x0)
    dut.U_IM.ROM[2] = 32'h00802383;  // lw   x7,8(x0)
    dut.U_IM.ROM[3] = 32'h00900013;  // addi x0,x0,9
    do_reset();
    step(4);
    chk_reg("p3_x7", 5'd7, 32'h00000055);
    chk_reg("p3_x0", 5'd0, 32'h0);

    // Program 4: illegal opcode, RAM survives reset, bne not taken, beq loop
    clear_rom();
    dut.U_IM.ROM[0] = 32'hFFFFFFFF;  // illegal
    dut.U_IM.ROM[2] = 32'h00802383;  // lw   x7,8(x0)
    dut.U_IM.ROM[3] = 32'h00001463;  // bne  x0,x0,+8
    dut.U_IM.ROM[4] = 32'hFE000EE3;  // beq  x0,x0,-4
    do_reset();
    step(1);
    chk_pc("p4_illegal_pc", 32'h4);
    chk_reg("p4_illegal_x31", 5'd31, 32'h0);
    step(2);
    chk_reg("p4_ram_kept", 5'd7, 32'h00000055);
    chk_pc("p4_pc_c", 32'hC);
    step(1);
    chk_pc("p4_bne_nt", 32'h10);
    step(1);
    chk_pc("p4_beq_t1", 32'hC);
    step(1);
    chk_pc("p4_loop_10", 32'h10);
    step(1);
    chk_pc("p4_beq_t2", 32'hC);

    // Program 5: shifts, signed/unsigned compare, blt, sub, lui, jalr
    clear_rom();
    dut.U_IM.ROM[0]  = 32'hFF800093;  // addi  x1,x0,-8
    dut.U_IM.ROM[1]  = 32'h4010D113;  // srai  x2,x1,1
    dut.U_IM.ROM[2]  = 32'h01C0D193;  // srli  x3,x1,28
    dut.U_IM.ROM[3]  = 32'h0030A233;  // slt   x4,x1,x3
    dut.U_IM.ROM[4]  = 32'h0030B2B3;  // sltu  x5,x1,x3
    dut.U_IM.ROM[5]  = 32'h0030C463;  // blt   x1,x3,+8
    dut.U_IM.ROM[6]  = 32'h00100313;  // addi  x6,x0,1 (skipped)
    dut.U_IM.ROM[7]  = 32'h40118333;  // sub   x6,x3,x1
    dut.U_IM.ROM[8]  = 32'h12345437;  // lui   x8,0x12345
    dut.U_IM.ROM[9]  = 32'h000083E7;  // jalr  x7,0(x1)
    do_reset();
    step(5);
    chk_reg("p5_srai", 5'd2, 32'hFFFFFFFC);
    chk_reg("p5_srli", 5'd3, 32'h0000000F);
    chk_reg("p5_slt",  5'd4, 32'h00000001);
    chk_reg("p5_sltu", 5'd5, 32'h00000000);
    chk_pc("p5_pc_blt", 32'h14);
    step(1);
    chk_pc("p5_blt_taken", 32'h1C);
    step(1);
    chk_reg("p5_sub", 5'd6, 32'h00000017);
    step(1);
    chk_reg("p5_lui", 5'd8, 32'h12345000);
    chk_pc("p5_pc_jalr", 32'h24);
    step(1);
`ifdef SCCOMP_JALR_EN
    chk_pc("p5_jalr_pc", 32'hFFFFFFF8);
    chk_reg("p5_jalr_x7", 5'd7, 32'h00000028);
`else
    chk_pc("p5_jalr_nop_pc", 32'h28);
    chk_reg("p5_jalr_nop_x7", 5'd7, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
